// File: rtl/modulo_contador_pkg.sv
// rtl/modulo_contador_pkg.sv - shared state encoding and width default for the count controller
package modulo_contador_pkg;

  localparam int WIDTH_DEFAULT = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } ctrl_state_t;

endpackage

// File: rtl/modulo_contador_sync_en.sv
// rtl/modulo_contador_sync_en.sv - WIDTH-bit up-counter with enable, synchronous load-zero, async clear
module modulo_contador_sync_en #(
  parameter int WIDTH = 7
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             load_zero,
  output logic [WIDTH-1:0] count
);

  // load_zero wins over enable so a restart never counts on its first edge
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (load_zero) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/modulo_controlador_contagem.sv
// rtl/modulo_controlador_contagem.sv - count sequencer FSM with limit latch; CONTROLADOR_AUTO_RELOAD_EN enables periodic reload
module modulo_controlador_contagem
  import modulo_contador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  ctrl_state_t      state_r;
  logic [WIDTH-1:0] lim_r;
  logic             cnt_en;
  logic             cnt_zero;
  logic             at_limit;

  assign at_limit = (q == lim_r);

  // Counter controls mirror the transitions below: zero on start, abort or reload
  always_comb begin
    cnt_en   = 1'b0;
    cnt_zero = 1'b0;
    case (state_r)
      ST_IDLE: cnt_zero = start && !abort;
      ST_RUN: begin
        cnt_zero = abort;
        cnt_en   = !abort && !hold && !at_limit;
      end
      ST_HOLD: cnt_zero = abort;
`ifdef CONTROLADOR_AUTO_RELOAD_EN
      ST_DONE: cnt_zero = 1'b1;
`else
      ST_DONE: cnt_zero = abort;
`endif
      default: cnt_zero = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r <= ST_IDLE;
      lim_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !abort) begin
            state_r <= ST_RUN;
            lim_r   <= limit;
          end
        end
        ST_RUN: begin
          if (abort)         state_r <= ST_IDLE;
          else if (hold)     state_r <= ST_HOLD;
          else if (at_limit) state_r <= ST_DONE;
        end
        ST_HOLD: begin
          if (abort)      state_r <= ST_IDLE;
          else if (!hold) state_r <= ST_RUN;
        end
        ST_DONE: begin
`ifdef CONTROLADOR_AUTO_RELOAD_EN
          if (abort)     state_r <= ST_IDLE;
          else if (hold) state_r <= ST_HOLD;
          else           state_r <= ST_RUN;
`else
          state_r <= ST_IDLE;
`endif
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  modulo_contador_sync_en #(.WIDTH(WIDTH)) u_contador (
    .clock     (clock),
    .clear     (clear),
    .enable    (cnt_en),
    .load_zero (cnt_zero),
    .count     (q)
  );

  assign busy  = (state_r == ST_RUN) || (state_r == ST_HOLD);
  assign done  = (state_r == ST_DONE);
  assign state = state_r;

endmodule

// File: tb/tb_modulo_controlador_contagem.sv
// tb/tb_modulo_controlador_contagem.sv - self-checking bench for modulo_controlador_contagem
module tb_modulo_controlador_contagem;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic       hold  = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] limit = 7'd0;
  logic [6:0] q;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;
  int n_run, n_hold, n_done, max_q;

  // Reference: mode 0=idle 1=run 2=hold 3=done, as the externally visible state code
  int m_mode = 0;
  int m_q    = 0;
  int m_lim  = 0;

  modulo_controlador_contagem #(.WIDTH(7)) dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .hold  (hold),
    .abort (abort),
    .limit (limit),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .state (state)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_mode <= 0; m_q <= 0; m_lim <= 0;
    end else begin
      case (m_mode)
        0: if (start && !abort) begin m_mode <= 1; m_q <= 0; m_lim <= int'(limit); end
        1: begin
          if (abort) begin m_mode <= 0; m_q <= 0; end
          else if (hold) m_mode <= 2;
          else if (m_q == m_lim) m_mode <= 3;
          else m_q <= m_q + 1;
        end
        2: begin
          if (abort) begin m_mode <= 0; m_q <= 0; end
          else if (!hold) m_mode <= 1;
        end
        default: begin
          if (abort) begin m_mode <= 0; m_q <= 0; end
`ifdef CONTROLADOR_AUTO_RELOAD_EN
          else begin m_q <= 0; m_mode <= hold ? 2 : 1; end
`else
          else m_mode <= 0;
`endif
        end
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    n_run = 0; n_hold = 0; n_done = 0; max_q = 0;
  endtask

  // Compare against the model mid-cycle, then advance one edge and gather stats
  task automatic tick();
    @(negedge clock);
    chk("model_q", int'(q), m_q);
    chk("model_state", int'(state), m_mode);
    chk("model_busy", int'(busy), (m_mode == 1 || m_mode == 2) ? 1 : 0);
    chk("model_done", int'(done), (m_mode == 3) ? 1 : 0);
    @(posedge clock);
    #1;
    if (state == 2'd1) n_run++;
    if (state == 2'd2) n_hold++;
    if (done) n_done++;
    if (int'(q) > max_q) max_q = int'(q);
  endtask

  task automatic begin_seq(input int lim);
    limit = 7'(lim);
    start = 1'b1;
    clear_stats();
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int max);
    int k = 0;
    while (state != 2'd3 && k < max) begin tick(); k++; end
    chk("reach_done", int'(state), 3);
  endtask

  task automatic run_until_q(input int val, input int max);
    int k = 0;
    while (int'(q) != val && k < max) begin tick(); k++; end
    chk("reach_q", int'(q), val);
  endtask

  task automatic finish_seq();
`ifdef CONTROLADOR_AUTO_RELOAD_EN
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    tick();
`endif
    chk("back_idle", int'(state), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 clear = 1'b0;
    #2;
    chk("rst_q", int'(q), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clock); #1;
    clear = 1'b1;
    tick(); tick();

    // limit 5, limit input changed after the start is accepted
    begin_seq(5);
    limit = 7'd2;
    run_until_done(20);
    chk("l5_run_cycles", n_run, 6);
    chk("l5_done_count", n_done, 1);
    chk("l5_q_at_done", int'(q), 5);
    finish_seq();
`ifndef CONTROLADOR_AUTO_RELOAD_EN
    chk("l5_q_idle", int'(q), 5);
`endif

    begin_seq(0);
    run_until_done(5);
    chk("l0_run_cycles", n_run, 1);
    chk("l0_q", int'(q), 0);
    finish_seq();

    begin_seq(127);
    run_until_done(200);
    chk("l127_run_cycles", n_run, 128);
    chk("l127_max_q", max_q, 127);
    chk("l127_done_count", n_done, 1);
    finish_seq();
`ifndef CONTROLADOR_AUTO_RELOAD_EN
    chk("l127_q_idle", int'(q), 127);
`endif

    // hold at q=4 with limit 10
    begin_seq(10);
    run_until_q(4, 10);
    hold = 1'b1;
    tick(); tick();
    chk("hold_state", int'(state), 2);
    chk("hold_q", int'(q), 4);
    hold = 1'b0;
    run_until_done(30);
    chk("hold_cycles", n_hold, 2);
    chk("hold_total", n_run + n_hold, 14);
    chk("hold_q_final", int'(q), 10);
    finish_seq();

    // hold on the same cycle q reaches the limit defers DONE
    begin_seq(2);
    run_until_q(2, 10);
    hold = 1'b1;
    tick(); tick();
    chk("hl_state", int'(state), 2);
    chk("hl_no_done", n_done, 0);
    hold = 1'b0;
    run_until_done(10);
    chk("hl_run_cycles", n_run, 4);
    finish_seq();

    // abort at q=7 with a stray start during RUN
    begin_seq(20);
    run_until_q(3, 10);
    start = 1'b1; limit = 7'd3;
    tick();
    start = 1'b0;
    chk("ab_ignore_start", int'(q), 4);
    run_until_q(7, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_state", int'(state), 0);
    chk("ab_q", int'(q), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_done_count", n_done, 0);
    tick();

    // asynchronous clear between edges at q=9
    begin_seq(15);
    run_until_q(9, 15);
    #2 clear = 1'b0;
    #1;
    chk("clr_q", int'(q), 0);
    chk("clr_state", int'(state), 0);
    chk("clr_busy", int'(busy), 0);
    #2 clear = 1'b1;
    tick(); tick(); tick();
    chk("clr_stays_idle", int'(state), 0);

    // reload behaviour with limit 3 over 20 sampled cycles
    begin_seq(3);
    repeat (19) tick();
`ifdef CONTROLADOR_AUTO_RELOAD_EN
    chk("rl_done_pulses", n_done, 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("rl_abort_idle", int'(state), 0);
    repeat (6) tick();
    chk("rl_no_more_done", n_done, 4);
`else
    chk("rl_single_done", n_done, 1);
    chk("rl_idle", int'(state), 0);
    chk("rl_q", int'(q), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
